// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b - bin), LSB first, valid/ready on both sides.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, nxt;
  logic [WIDTH-1:0] ra, rb, acc, res_nxt;
  logic [CW-1:0]    cnt;
  logic             br, d_bit, br_nxt;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Current bit always sits at position 0 of the operand registers.
  always_comb begin
    d_bit   = ra[0] ^ rb[0] ^ br;
    br_nxt  = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
    res_nxt = {d_bit, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ra   <= '0;
      rb   <= '0;
      acc  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ra  <= a;
            rb  <= b;
            br  <= bin;
            cnt <= '0;
          end
        end
        SHIFT: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          acc <= res_nxt;
          br  <= br_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            diff <= res_nxt;
            bout <= br_nxt;
            zero <= (res_nxt == '0);
`ifdef SERIAL_SUB_OVF_EN
            // On the last step ra[0]/rb[0] are the original operand MSBs.
            ovf  <= (ra[0] ^ rb[0]) & (ra[0] ^ d_bit);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per clock, LSB first.
- Borrow is held in a flip-flop between bit steps instead of being propagated combinationally.
- Area-lean companion to the combinational ripple-carry adder; used in datapaths where multi-cycle latency is acceptable.
- Operands enter and results leave through valid/ready handshakes.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand set valid
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow-in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  borrow-out (1 when a < b + bin, unsigned)
zero  output  1  diff == 0
busy  output  1  operation in progress (SHIFT state)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset; it has priority over all other inputs.
- Reset values:
  - State is IDLE.
  - out_valid=0, diff=0, bout=0, zero=0, busy=0.
  - Internal borrow flop=0, bit counter=0.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE), combinational. A handshake is in_valid & in_ready sampled at a rising edge with reset low. A handshake in a cycle where reset is high is discarded.
- IDLE:
  - On handshake, latch a, b and bin (bin goes into the borrow flop), clear counter, go to SHIFT.
  - Without a handshake, stay in IDLE.
- SHIFT, one bit per cycle (i = counter):
  - d_i = a_i ^ b_i ^ br
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d_i shifts into the result register from the MSB end (shift right). The operand registers shift right with it.
  - After the WIDTH-th bit step, go to DONE.
  - busy=1 throughout SHIFT.
  - The in_valid/in_ready handshake is only accepted in IDLE, so new operands are refused in SHIFT.
- DONE:
  - out_valid=1.
  - diff holds the full result, bout holds the final borrow, zero = (diff==0).
  - All three stay stable until out_valid & out_ready at a rising edge; then go to IDLE.
  - out_valid falls in the following cycle.
- diff, bout and zero change only on the SHIFT->DONE transition and on reset. They are don't-care when out_valid=0 (the implementation keeps the last value).
- Latency: handshake in cycle 0; SHIFT occupies cycles 1..WIDTH; out_valid=1 from cycle WIDTH+1. Minimum issue interval is WIDTH+2 cycles.
- Operand changes: a, b and bin are ignored outside the IDLE handshake. Changing the inputs during SHIFT or DONE has no effect.
- out_ready held high: DONE lasts exactly one cycle.
- out_ready low: DONE holds indefinitely; in_ready stays 0.
- Reset asserted in any state (including mid-SHIFT): the operation is abandoned and no result is produced. Reset values apply at the next edge, and in_ready=1 in the first cycle after reset deasserts.
- Width rules: all arithmetic is modulo 2^WIDTH. bout equals the borrow out of bit WIDTH-1.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN
- When defined:
  - Adds output port ovf (1 bit): signed overflow, = (a_msb ^ b_msb) & (a_msb ^ diff_msb), using the latched operands.
  - ovf is registered with diff and valid under the same out_valid rules.
  - ovf resets to 0.
- When undefined: port ovf and its logic are absent, and all other behaviour is identical.

Test Plan:
- Basic subtract: a=8'h35, b=8'h12, bin=0 handshake, out_ready=1 -> out_valid in cycle 9; diff=8'h23, bout=0, zero=0; busy=1 for cycles 1..8.
- Wrap and borrow: a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1. Then a=8'h80, b=8'h80, bin=1 -> diff=8'hFF, bout=1.
- Zero flag: a=8'h5A, b=8'h5A, bin=0 -> diff=8'h00, zero=1, bout=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid, in_valid=1 with new operands throughout -> diff stable, in_ready=0, no new accept. Then raise out_ready -> IDLE next cycle; the new operand is accepted in the cycle after that.
- Reset mid-op: accept a=8'hF0, b=8'h0F; assert reset in SHIFT cycle 3 -> next cycle out_valid=0, busy=0, diff=0, in_ready=1 after deassert; no stale result appears.
- SERIAL_SUB_OVF_EN defined: a=8'h80, b=8'h01 -> diff=8'h7F, bout=0, ovf=1. Then a=8'h10, b=8'h01 -> ovf=0.
